operand_sel_stage: RTL
======================

// Module: operand_sel_stage
// PURPOSE
// - Parametrised N:1 operand-select pipeline stage. Successor to the 3:1 forwarding mux:
//   generic width and input count, registered output, valid/ready handshake, flush, select-error tracking.
// - Sits between the register-read/forwarding sources and the EX-stage ALU operand inputs.
// PARAMETERS
// - WIDTH   64  data width of each source and of data_out
// - NUM_IN  3   number of sources, >= 2
// - SEL_W   2   select width; must satisfy 2**SEL_W >= NUM_IN
// - CNT_W   8   width of the saturating select-error counter
// PORTS
// - clk        in   1            rising-edge clock
// - rst_n      in   1            asynchronous active-low reset
// - flush      in   1            synchronous pipeline flush
// - in_valid   in   1            upstream beat valid
// - in_ready   out  1            stage can accept a beat
// - sel        in   SEL_W        source index for this beat
// - data_in    in   NUM_IN*WIDTH packed sources; source k = data_in[k*WIDTH +: WIDTH]
// - out_valid  out  1            data_out holds a valid beat
// - out_ready  in   1            downstream accepts the beat
// - data_out   out  WIDTH        selected operand, registered
// - sel_err    out  1            the current output beat had an out-of-range sel
// - err_cnt    out  CNT_W        saturating count of accepted out-of-range beats
// BEHAVIOUR
// - Reset: one clock, clk; reset is asynchronous and active-low (rst_n). While low: out_valid=0, data_out=0,
//   sel_err=0, err_cnt=0, internal skid empty. in_ready=1 during and after reset.
// - Accept = in_valid & in_ready & ~flush. Latency 1: the accepted beat appears on data_out with out_valid=1
//   on the next edge.
// - Select: sel < NUM_IN -> source sel. sel >= NUM_IN -> data 0 and sel_err=1, registered with the beat.
// - Transfer out = out_valid & out_ready. Stall (out_valid & ~out_ready): data_out, sel_err and out_valid
//   hold stable.
// - Simultaneous transfer out + accept: the new beat replaces the output register. No bubble.
// - Ordering is strict FIFO. No beat is duplicated or dropped, except by flush.
// - flush: on the next edge out_valid=0 and the skid is emptied. An input presented in the flush cycle is
//   dropped. flush has priority over accept. data_out is not cleared. err_cnt is not cleared.
// - err_cnt: increments by 1 per accepted beat with sel >= NUM_IN. It saturates at 2**CNT_W-1 and does not
//   wrap. Only rst_n clears it.
// - Reset mid-operation: all beats in flight are discarded immediately (async). No output glitch back to valid.
// CONFIGURATION
// - Macro OPSEL_SKID_EN.
// - Defined: one-entry skid buffer; in_ready is a register with no combinational path from out_ready.
//   - in_ready = ~skid_full.
//   - A beat accepted while the output is stalled goes to the skid.
//   - The skid drains to the output register on the next transfer out.
//   - Sustained throughput is 1 beat/cycle; capacity is 2 beats.
// - Undefined: no skid. in_ready = ~out_valid | out_ready (combinational). Capacity is 1 beat; throughput is
//   1 beat/cycle while out_ready=1.
// - Both builds must give identical output sequences for identical accepted inputs.
// TESTING
// - Use WIDTH=64, NUM_IN=3 unless a scenario says otherwise.
// - Reset: hold rst_n=0 mid-stream with out_valid=1 -> out_valid=0, data_out=0, err_cnt=0 immediately; in_ready=1.
// - Streaming: out_ready=1, sel=0,1,2 with data_in={C,B,A} -> data_out=A,B,C on consecutive cycles, 1-cycle latency.
// - Stall: accept A, out_ready=0 for 3 cycles, in_valid=1 with B.
//   - No skid: in_ready=0 and data_out=A held.
//   - OPSEL_SKID_EN: B is taken into the skid, then in_ready=0.
//   - Release out_ready: A then B, nothing lost.
// - Bad select: sel=3 -> data_out=0, sel_err=1, err_cnt+1. With CNT_W=2 and 5 bad beats -> err_cnt=3 (saturated).
// - Flush: out_valid=1, skid full (skid build), flush=1 with in_valid=1 -> next cycle out_valid=0, the input is
//   dropped, err_cnt unchanged.
// - Parameter sweep: NUM_IN=5, SEL_W=3, WIDTH=32. Sel 0..4 return the matching sources; sel 5..7 give 0 with sel_err=1.

Source files
------------

// File: rtl/operand_sel_stage.sv
// N:1 operand-select pipeline stage with registered output, valid/ready, flush and select-error counter.
// Optional one-entry skid buffer (registered in_ready) enabled by macro OPSEL_SKID_EN.
module operand_sel_stage #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        err_cnt
);

  logic [WIDTH-1:0] sel_dat;
  logic             sel_bad;
  logic             accept;

  // Out-of-range selects fall through to zero data with the error flag set.
  always_comb begin
    sel_dat = '0;
    sel_bad = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_dat = data_in[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    end
  end

  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && sel_bad && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

`ifdef OPSEL_SKID_EN
  logic             skid_full;
  logic [WIDTH-1:0] skid_dat;
  logic             skid_err;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sel_err   <= 1'b0;
      skid_full <= 1'b0;
      skid_dat  <= '0;
      skid_err  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output register is free this edge; skid (older beat) wins over the input.
      if (skid_full) begin
        out_valid <= 1'b1;
        data_out  <= skid_dat;
        sel_err   <= skid_err;
        skid_full <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          data_out <= sel_dat;
          sel_err  <= sel_bad;
        end
      end
    end else if (accept) begin
      skid_full <= 1'b1;
      skid_dat  <= sel_dat;
      skid_err  <= sel_bad;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sel_err   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= accept;
      if (accept) begin
        data_out <= sel_dat;
        sel_err  <= sel_bad;
      end
    end
  end
`endif

endmodule
